// File: rtl/intra_tap_sum_pack.sv
// intra_tap_sum_pack: sums the four selected tap products of one intra angular
// predicted sample, applies the filter rounding and shift, clips the result to
// the sample bit depth, and packs consecutive samples into row words.
//
// Handshake: a word moves across an interface on a rising edge where its
// valid and ready are both high. The producer holds valid and data stable
// until that edge. The whole pipeline advances only when en is high, where
// en = !out_valid || out_ready. in_ready is en itself, so a stalled row
// freezes stage 1 and the packer, and no sample is lost. in_ready is the
// only combinational path from out_ready.
module intra_tap_sum_pack #(
  parameter int PROD_W    = 16,
  parameter int BIT_DEPTH = 8,
  parameter int SHIFT     = 6,
  parameter int ROW_LEN   = 4,
  localparam int CNT_W    = $clog2(ROW_LEN) + 1,
  localparam int ROW_W    = ROW_LEN * BIT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] p0,
  input  logic [PROD_W-1:0] p1,
  input  logic [PROD_W-1:0] p2,
  input  logic [PROD_W-1:0] p3,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_row,
  output logic [CNT_W-1:0]  out_cnt
);

  localparam int SUM_W = PROD_W + 2;
  localparam int RND_W = PROD_W + 3;
  localparam int RND_OFF = 1 << (SHIFT - 1);
  localparam logic signed [RND_W-1:0] RND_OFF_S = RND_W'(RND_OFF);
  localparam logic signed [RND_W-1:0] MAX_S     = RND_W'((1 << BIT_DEPTH) - 1);

  logic en;

  // Stage 1 registers
  logic [SUM_W-1:0] s1_sum_q, s1_sum_d;
  logic             s1_last_q, s1_last_d;
  logic             s1_valid_q, s1_valid_d;

  // Packer and output registers
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_buf_q, row_buf_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_valid_q, out_valid_d;

  // Stage 2 combinational signals
  logic signed [RND_W-1:0] rnd_sum;
  logic signed [RND_W-1:0] rnd_shr;
  logic [BIT_DEPTH-1:0]    sample;
  logic [ROW_W-1:0]        row_next;
  logic                    row_done;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_cnt   = out_cnt_q;

  // Stage 1: sign-extended sum of the four products, captured whenever the pipe advances
  always_comb begin
    s1_sum_d   = s1_sum_q;
    s1_last_d  = s1_last_q;
    s1_valid_d = s1_valid_q;
    if (en) begin
      s1_sum_d   = {{2{p0[PROD_W-1]}}, p0} + {{2{p1[PROD_W-1]}}, p1}
                 + {{2{p2[PROD_W-1]}}, p2} + {{2{p3[PROD_W-1]}}, p3};
      s1_last_d  = in_last;
      s1_valid_d = in_valid;
    end
  end

  // Stage 2: round, arithmetic shift, clip to [0, 2^BIT_DEPTH-1]
  always_comb begin
    rnd_sum = $signed({s1_sum_q[SUM_W-1], s1_sum_q}) + RND_OFF_S;
    rnd_shr = rnd_sum >>> SHIFT;
    if (rnd_shr[RND_W-1]) begin
      sample = '0;
    end else if (rnd_shr > MAX_S) begin
      sample = '1;
    end else begin
      sample = rnd_shr[BIT_DEPTH-1:0];
    end
  end

  // Packer: drop the sample into lane cnt and publish the row when it closes
  always_comb begin
    cnt_d       = cnt_q;
    row_buf_d   = row_buf_q;
    out_row_d   = out_row_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    row_next    = row_buf_q;
    for (int i = 0; i < ROW_LEN; i++) begin
      if (CNT_W'(i) == cnt_q) begin
        row_next[i*BIT_DEPTH +: BIT_DEPTH] = sample;
      end else if (CNT_W'(i) > cnt_q) begin
        // lanes beyond the current sample are never valid in a completed row
        row_next[i*BIT_DEPTH +: BIT_DEPTH] = '0;
      end
    end
    row_done = s1_valid_q && ((cnt_q == CNT_W'(ROW_LEN - 1)) || s1_last_q);
    if (en) begin
      // with en high, a pending row is either absent or leaving this edge
      out_valid_d = 1'b0;
      if (s1_valid_q) begin
        if (row_done) begin
          out_row_d   = row_next;
          out_cnt_d   = cnt_q + CNT_W'(1);
          out_valid_d = 1'b1;
          cnt_d       = '0;
          row_buf_d   = '0;
        end else begin
          row_buf_d   = row_next;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State registers; reset discards stage 1, any partial row and any pending output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sum_q    <= '0;
      s1_last_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      cnt_q       <= '0;
      row_buf_q   <= '0;
      out_row_q   <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_sum_q    <= s1_sum_d;
      s1_last_q   <= s1_last_d;
      s1_valid_q  <= s1_valid_d;
      cnt_q       <= cnt_d;
      row_buf_q   <= row_buf_d;
      out_row_q   <= out_row_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_intra_tap_sum_pack.sv
// Directed bench for intra_tap_sum_pack: sum/round/clip, row packing,
// partial rows, backpressure, coincident transfer/completion and async reset.
module tb_intra_tap_sum_pack;

  localparam int E_W = 35;  // {out_cnt[2:0], out_row[31:0]}

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] p0, p1, p2, p3;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_row;
  logic [2:0]         out_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [E_W-1:0] exp_q[$];
  logic [E_W-1:0] obs_q[$];

  intra_tap_sum_pack #(
    .PROD_W(16), .BIT_DEPTH(8), .SHIFT(6), .ROW_LEN(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p0        (p0),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_cnt   (out_cnt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // output monitor: a row seen valid&&ready here leaves on the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) obs_q.push_back({out_cnt, out_row});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) tick();
  endtask

  // driver: present products and hold them until accepted (bounded)
  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic signed [15:0] c, input logic signed [15:0] d,
                      input logic last);
    logic acc;
    int   n;
    in_valid = 1'b1;
    p0 = a; p1 = b; p2 = c; p3 = d;
    in_last = last;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    chk("send_accept", 64'(acc), 64'd1);
  endtask

  // a sample whose clipped value is exactly v
  task automatic send_val(input int v, input logic last);
    send(16'(v * 64), 16'sd0, 16'sd0, 16'sd0, last);
  endtask

  task automatic expect_row(input logic [2:0] c, input logic [31:0] r);
    exp_q.push_back({c, r});
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    p0 = '0; p1 = '0; p2 = '0; p3 = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_row", 64'(out_row), 64'd0);
    chk("rst_out_cnt", 64'(out_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    tick();

    // full row of X=100 through taps -4/36/36/-4, with latency check
    for (int i = 0; i < 4; i++) send(-16'sd400, 16'sd3600, 16'sd3600, -16'sd400, 1'b0);
    expect_row(3'd4, 32'h64646464);
    in_valid = 1'b0;
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    tick();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_row", 64'(out_row), 64'h64646464);
    chk("lat_cnt", 64'(out_cnt), 64'd4);
    tick();
    chk("lat_drained", 64'(out_valid), 64'd0);
    idle(2);

    // clip: -2000 -> 0, 4*16000 -> 255, 95 -> 1, -33 -> 0
    send(-16'sd2000, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    send(16'sd16000, 16'sd16000, 16'sd16000, 16'sd16000, 1'b0);
    send(16'sd95, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    send(-16'sd33, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    expect_row(3'd4, 32'h0001FF00);
    idle(4);

    // partial row closed by in_last, then a full row starting at lane 0
    send_val(10, 1'b0);
    send_val(20, 1'b0);
    send_val(30, 1'b1);
    expect_row(3'd3, 32'h001E140A);
    send_val(1, 1'b0);
    chk("part_valid", 64'(out_valid), 64'd1);
    chk("part_row", 64'(out_row), 64'h001E140A);
    chk("part_cnt", 64'(out_cnt), 64'd3);
    send_val(2, 1'b0);
    send_val(3, 1'b0);
    send_val(4, 1'b0);
    expect_row(3'd4, 32'h04030201);
    idle(4);

    // backpressure: pending row holds, input stalls, stream resumes in order
    out_ready = 1'b0;
    send_val(5, 1'b0);
    send_val(6, 1'b0);
    send_val(7, 1'b0);
    send_val(8, 1'b0);
    expect_row(3'd4, 32'h08070605);
    send_val(9, 1'b0);
    p0 = 16'(10 * 64);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_row", 64'(out_row), 64'h08070605);
      chk("bp_cnt", 64'(out_cnt), 64'd4);
    end
    out_ready = 1'b1;
    send_val(10, 1'b0);
    send_val(11, 1'b0);
    send_val(12, 1'b0);
    expect_row(3'd4, 32'h0C0B0A09);
    idle(4);

    // output transfer coincides with completion of a one-sample row
    out_ready = 1'b0;
    send_val(21, 1'b0);
    send_val(22, 1'b0);
    send_val(23, 1'b0);
    send_val(24, 1'b0);
    expect_row(3'd4, 32'h18171615);
    send_val(25, 1'b1);
    expect_row(3'd1, 32'h00000019);
    in_valid = 1'b0;
    in_last = 1'b0;
    tick();
    chk("sim_hold_row", 64'(out_row), 64'h18171615);
    out_ready = 1'b1;
    tick();
    chk("sim_valid", 64'(out_valid), 64'd1);
    chk("sim_row", 64'(out_row), 64'h00000019);
    chk("sim_cnt", 64'(out_cnt), 64'd1);
    tick();
    chk("sim_drained", 64'(out_valid), 64'd0);
    idle(2);

    // asynchronous reset mid-row after two samples
    send_val(40, 1'b0);
    send_val(41, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("mid_cnt_before", 64'(dut.cnt_q), 64'd2);
    rst = 1'b1;
    #2;
    chk("mid_cnt_async", 64'(dut.cnt_q), 64'd0);
    chk("mid_valid_async", 64'(out_valid), 64'd0);
    chk("mid_s1_async", 64'(dut.s1_valid_q), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    send_val(60, 1'b0);
    send_val(61, 1'b0);
    send_val(62, 1'b0);
    send_val(63, 1'b0);
    expect_row(3'd4, 32'h3F3E3D3C);
    idle(5);

    // scoreboard: every issued row, in order
    chk("sb_row_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("sb_row%0d", i),
          64'((i < obs_q.size()) ? obs_q[i] : {E_W{1'b1}}), 64'(exp_q[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/intra_tap_sum_pack.md
Name: intra_tap_sum_pack

Overview:
- Downstream of the per-tap MCM constant-multiplier blocks in the intra angular predictor.
- Takes the four already-selected signed tap products for one predicted sample and sums them.
- Applies the filter rounding and shift, then clips the result to the sample bit depth.
- Packs consecutive clipped samples into a row word for the prediction writer.
- Two-stage pipeline with a valid/ready handshake on both sides.

Parameters:
- PROD_W, 16, width of each signed tap product (matches the MCM output width)
- BIT_DEPTH, 8, output sample width; clip range is [0, 2^BIT_DEPTH-1]
- SHIFT, 6, filter normalisation shift; rounding offset is 1<<(SHIFT-1)
- ROW_LEN, 4, samples per packed output row

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  tap products valid
- in_ready  out  1  block accepts the products this cycle
- p0  in  PROD_W  signed product, tap 0
- p1  in  PROD_W  signed product, tap 1
- p2  in  PROD_W  signed product, tap 2
- p3  in  PROD_W  signed product, tap 3
- in_last  in  1  this sample closes the row early (partial row)
- out_valid  out  1  packed row available
- out_ready  in  1  consumer accepts the row
- out_row  out  ROW_LEN*BIT_DEPTH  packed samples; sample 0 in the LSBs
- out_cnt  out  clog2(ROW_LEN)+1  number of valid samples in out_row (1..ROW_LEN)

Behaviour:
- Single clock domain; the reset is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_row=0, out_cnt=0.
  - Stage-1 valid=0, packer count=0, internal row buffer=0.
- Global enable: en = !out_valid || out_ready. in_ready = en, combinational; it is the only combinational path from out_ready.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage 1, registered when en:
  - s1_sum = sext(p0)+sext(p1)+sext(p2)+sext(p3), width PROD_W+2, no overflow possible.
  - s1_last = in_last.
  - s1_valid = input transfer.
- Stage 2, combinational on s1:
  - r = (s1_sum + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, computed at PROD_W+3 bits.
  - r < 0 → 0; r > 2^BIT_DEPTH-1 → 2^BIT_DEPTH-1; otherwise r[BIT_DEPTH-1:0].
- Packer, updated when en && s1_valid:
  - Write the clipped sample into lane cnt of the row buffer, then cnt = cnt+1.
  - When cnt == ROW_LEN-1 or s1_last=1, the row completes.
  - On completion, out_row is loaded with the buffer including the new lane, with unfilled lanes forced to 0.
  - On completion, out_cnt = cnt+1 and out_valid=1.
  - After completion, cnt=0 and the row buffer is cleared.
- out_valid clears on an output transfer that does not coincide with a new completion. If a row completes in the same cycle an output transfer occurs, out_valid stays 1 with the new contents.
- While out_valid && !out_ready:
  - en=0, so stage 1, the packer and the outputs hold.
  - in_ready=0 and no input is lost.
  - out_row and out_cnt are stable.
- Latency:
  - An input transferred at edge k appears in stage 1 after edge k.
  - It is packed at edge k+1.
  - If it completes a row, out_valid is high in the cycle after edge k+1 (2 cycles).
- Throughput: one sample per cycle with no bubbles when out_ready=1. A full row is issued every ROW_LEN accepted samples.
- in_last on the first sample of a row gives out_cnt=1 with only lane 0 non-zero.
- Reset asserted mid-row discards the partial row and any pending output immediately (asynchronous), with no output transfer.
- in_valid with in_ready=0 has no effect; the upstream holds its data.

Test Plan:
- Reset, then ROW_LEN=4 accepted inputs, each p0=-400, p1=3600, p2=3600, p3=-400 (X=100, taps -4/36/36/-4), out_ready=1 → out_valid exactly 2 cycles after the 4th transfer; out_row lanes all 100 (0x64646464); out_cnt=4.
- Clip checks:
  - p0=-2000, others 0 → lane value 0.
  - p0=p1=p2=p3=16000 → 255.
  - Sum=95 → (95+32)>>6 = 1.
  - Sum=-33 → (-33+32)>>>6 = -1 → 0.
- Partial row: three samples of value 10, 20, 30 with in_last on the third → out_cnt=3, out_row=0x001E140A; the next row starts at lane 0.
- Backpressure:
  - Hold out_ready=0 with a full row pending → in_ready=0, out_row stable, no samples dropped.
  - Release out_ready during a continuous stream → the next row is issued with the correct ordered lanes and no gaps.
- Simultaneous events: the output transfer and a new row completion in the same cycle → out_valid stays 1 with the new row; the count sequence is unbroken.
- Reset asserted mid-row after two samples → out_valid=0 and the count is cleared asynchronously. A subsequent 4-sample stream produces a row containing only post-reset samples.
